// File: rtl/ctr_stream_if.sv
// ctr_stream_if: block stream between the DMA/stream fabric and ctr_stream_ctrl.
//   in_valid/in_ready/in_data       : 128-bit input blocks (fabric -> controller)
//   out_valid/out_ready/out_data    : 128-bit result blocks (controller -> fabric)
//   out_last                        : final block of the message
//   out_bytes                       : valid bytes in out_data, 1..16 (LSB aligned)
// master = fabric side, slave = controller side.
interface ctr_stream_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic [4:0]   out_bytes;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_bytes
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_bytes
    );
endinterface

// File: rtl/ctr_stream_ctrl.sv
// ctr_stream_ctrl: sequences one message through ctr_core.
// Loads key/IV with core_init, then issues core_next per full 16-byte block and
// core_finalize (with bit length) for the last block. Core inputs are held stable
// while the core works; core results are registered and masked to the valid bytes.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, msg_bytes, iv, key, keylen   message request (sampled on start in IDLE)
//   busy, done, error            status (done = 1-cycle pulse, error = sticky watchdog)
//   strm                         block stream (ctr_stream_if.slave)
//   core_init/next/finalize      1-cycle command pulses to ctr_core
//   core_init_counter, core_key, core_keylen, core_block_i, core_len_i   held core inputs
//   core_block_o, core_ready     core result and completion pulse
//
// Optional feature macro: CTR_WATCHDOG_EN
//   defined   : a counter aborts the message if core_ready does not arrive within
//               WDOG_MAX cycles of a command (error=1, done pulse, back to IDLE).
//   undefined : no counter, error stays 0, core_ready is awaited indefinitely.
module ctr_stream_ctrl #(
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned WDOG_MAX = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   msg_bytes,
    input  logic [127:0]       iv,
    input  logic [255:0]       key,
    input  logic               keylen,
    output logic               busy,
    output logic               done,
    output logic               error,
    ctr_stream_if.slave        strm,
    output logic               core_init,
    output logic               core_next,
    output logic               core_finalize,
    output logic [127:0]       core_init_counter,
    output logic [255:0]       core_key,
    output logic               core_keylen,
    output logic [127:0]       core_block_i,
    output logic [7:0]         core_len_i,
    input  logic [127:0]       core_block_o,
    input  logic               core_ready
);

    localparam int unsigned BLK_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT_IN,
        RUN,
        WAIT_CORE,
        OUT,
        FIN
    } state_t;

    state_t state_q, state_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [127:0]       out_data_q, out_data_d;
    logic [4:0]         out_bytes_q, out_bytes_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               last_q, last_d;
    logic               init_q, init_d;
    logic               next_q, next_d;
    logic               fin_q, fin_d;
    logic [127:0]       iv_q, iv_d;
    logic [255:0]       key_q, key_d;
    logic               keylen_q, keylen_d;
    logic [127:0]       block_q, block_d;
    logic [7:0]         len_q, len_d;
    logic [4:0]         nbytes_c;

`ifdef CTR_WATCHDOG_EN
    localparam int unsigned WDOG_W = (WDOG_MAX < 2) ? 1 : $clog2(WDOG_MAX);
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
`else
    // WDOG_MAX has no effect without the watchdog; this empty block keeps it referenced.
    if (WDOG_MAX == 0) begin : g_wdog_unused
    end
`endif

    // Byte-lane mask keeping the nbytes least-significant bytes.
    function automatic logic [127:0] byte_mask(input logic [4:0] nbytes);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < BLK_BYTES; i++) begin
            if (5'(i) < nbytes) begin
                m[i*8 +: 8] = 8'hff;
            end
        end
        return m;
    endfunction

    // Bytes carried by the block currently in the core.
    assign nbytes_c = last_q ? rem_q[4:0] : 5'(BLK_BYTES);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
            rem_q       <= '0;
            last_q      <= 1'b0;
            init_q      <= 1'b0;
            next_q      <= 1'b0;
            fin_q       <= 1'b0;
            iv_q        <= '0;
            key_q       <= '0;
            keylen_q    <= 1'b0;
            block_q     <= '0;
            len_q       <= '0;
`ifdef CTR_WATCHDOG_EN
            wdog_q      <= '0;
`endif
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
            rem_q       <= rem_d;
            last_q      <= last_d;
            init_q      <= init_d;
            next_q      <= next_d;
            fin_q       <= fin_d;
            iv_q        <= iv_d;
            key_q       <= key_d;
            keylen_q    <= keylen_d;
            block_q     <= block_d;
            len_q       <= len_d;
`ifdef CTR_WATCHDOG_EN
            wdog_q      <= wdog_d;
`endif
        end
    end

    // Next-state and next-register logic. Core commands are registered at the
    // WAIT_IN handshake so the pulse is on the core port during the RUN cycle.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_bytes_d = out_bytes_q;
        rem_d       = rem_q;
        last_d      = last_q;
        init_d      = 1'b0;
        next_d      = 1'b0;
        fin_d       = 1'b0;
        iv_d        = iv_q;
        key_d       = key_q;
        keylen_d    = keylen_q;
        block_d     = block_q;
        len_d       = len_q;
`ifdef CTR_WATCHDOG_EN
        wdog_d      = '0;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    iv_d     = iv;
                    key_d    = key;
                    keylen_d = keylen;
                    rem_d    = msg_bytes;
                    last_d   = 1'b0;
                    error_d  = 1'b0;
                    busy_d   = 1'b1;
                    if (msg_bytes == '0) begin
                        state_d = FIN;
                    end else begin
                        init_d  = 1'b1;
                        state_d = INIT;
                    end
                end
            end

            INIT: begin
                if (core_ready) begin
                    in_ready_d = 1'b1;
                    state_d    = WAIT_IN;
                end
            end

            WAIT_IN: begin
                if (strm.in_valid && in_ready_q) begin
                    block_d    = strm.in_data;
                    in_ready_d = 1'b0;
                    // rem is compared before any subtraction so it never wraps.
                    if (rem_q > LEN_W'(BLK_BYTES)) begin
                        next_d = 1'b1;
                    end else begin
                        fin_d  = 1'b1;
                        len_d  = {rem_q[4:0], 3'b000};
                        last_d = 1'b1;
                    end
                    state_d = RUN;
                end
            end

            RUN: begin
                if (!last_q) begin
                    rem_d = rem_q - LEN_W'(BLK_BYTES);
                end
                state_d = WAIT_CORE;
            end

            WAIT_CORE: begin
                if (core_ready) begin
                    out_data_d  = core_block_o & byte_mask(nbytes_c);
                    out_bytes_d = nbytes_c;
                    out_last_d  = last_q;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end

            OUT: begin
                if (strm.out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = FIN;
                    end else begin
                        in_ready_d = 1'b1;
                        state_d    = WAIT_IN;
                    end
                end
            end

            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef CTR_WATCHDOG_EN
        // Counts wait cycles after each command; cleared in every other state.
        if (((state_q == INIT) || (state_q == WAIT_CORE)) && !core_ready) begin
            if (wdog_q == WDOG_W'(WDOG_MAX - 1)) begin
                error_d     = 1'b1;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end else begin
                wdog_d = wdog_q + WDOG_W'(1);
            end
        end
`endif
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;
    assign strm.in_ready     = in_ready_q;
    assign strm.out_valid    = out_valid_q;
    assign strm.out_data     = out_data_q;
    assign strm.out_last     = out_last_q;
    assign strm.out_bytes    = out_bytes_q;
    assign core_init         = init_q;
    assign core_next         = next_q;
    assign core_finalize     = fin_q;
    assign core_init_counter = iv_q;
    assign core_key          = key_q;
    assign core_keylen       = keylen_q;
    assign core_block_i      = block_q;
    assign core_len_i        = len_q;

endmodule

// File: tb/tb_ctr_stream_ctrl.sv
// tb_ctr_stream_ctrl: directed self-checking bench for ctr_stream_ctrl.
// A small behavioural stand-in for ctr_core answers each command after two
// cycles with a bench-chosen result block.
module tb_ctr_stream_ctrl;

    localparam int unsigned LEN_W = 16;
`ifdef CTR_WATCHDOG_EN
    localparam int STALL_CYC = 3;
`else
    localparam int STALL_CYC = 20;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic [LEN_W-1:0]   msg_bytes;
    logic [127:0]       iv;
    logic [255:0]       key;
    logic               keylen;
    logic               busy, done, error;
    logic               core_init, core_next, core_finalize;
    logic [127:0]       core_init_counter;
    logic [255:0]       core_key;
    logic               core_keylen;
    logic [127:0]       core_block_i;
    logic [7:0]         core_len_i;
    logic [127:0]       core_block_o;
    logic               core_ready;

    ctr_stream_if strm ();

    ctr_stream_ctrl #(.LEN_W(LEN_W), .WDOG_MAX(8)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .msg_bytes         (msg_bytes),
        .iv                (iv),
        .key               (key),
        .keylen            (keylen),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .strm              (strm),
        .core_init         (core_init),
        .core_next         (core_next),
        .core_finalize     (core_finalize),
        .core_init_counter (core_init_counter),
        .core_key          (core_key),
        .core_keylen       (core_keylen),
        .core_block_i      (core_block_i),
        .core_len_i        (core_len_i),
        .core_block_o      (core_block_o),
        .core_ready        (core_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_init, n_next, n_fin;
    logic         core_en;
    logic [127:0] core_resp;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Core stand-in: answers a command two edges after it is seen.
    initial begin
        core_ready   = 1'b0;
        core_block_o = '0;
        forever begin
            @(negedge clk);
            if ((core_init || core_next || core_finalize) && core_en) begin
                repeat (2) @(posedge clk);
                #1 core_ready = 1'b1;
                core_block_o  = core_resp;
                @(posedge clk);
                #1 core_ready = 1'b0;
            end
        end
    end

    // Command pulse counters.
    initial begin
        n_init = 0; n_next = 0; n_fin = 0;
        forever begin
            @(negedge clk);
            if (core_init)     n_init++;
            if (core_next)     n_next++;
            if (core_finalize) n_fin++;
        end
    end

    // in_ready and out_valid must never be high together.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) chk("mon_excl", 256'(strm.in_ready & strm.out_valid), 256'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic clr_counts();
        n_init = 0; n_next = 0; n_fin = 0;
    endtask

    task automatic start_msg(input logic [LEN_W-1:0] len, input logic [127:0] v,
                             input logic [255:0] k, input logic kl);
        msg_bytes = len; iv = v; key = k; keylen = kl; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] d, input string tag);
        bit seen = 0;
        strm.in_valid = 1'b1;
        strm.in_data  = d;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (strm.in_ready) seen = 1;
        end
        chk({tag, "_in_ready"}, 256'(seen), 256'(1));
        @(posedge clk);
        #1 strm.in_valid = 1'b0;
    endtask

    // Called in the RUN cycle; leaves at #1 after the following edge.
    task automatic check_cmd(input string tag, input logic exp_next, input logic exp_fin,
                             input logic [7:0] exp_len, input logic [127:0] exp_blk);
        @(negedge clk);
        chk({tag, "_next"},  256'(core_next), 256'(exp_next));
        chk({tag, "_fin"},   256'(core_finalize), 256'(exp_fin));
        chk({tag, "_blk_i"}, 256'(core_block_i), 256'(exp_blk));
        if (exp_fin) chk({tag, "_len"}, 256'(core_len_i), 256'(exp_len));
        @(posedge clk);
        #1;
    endtask

    task automatic recv_block(input logic [127:0] d, input logic [4:0] nb, input logic lst,
                              input string tag);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (strm.out_valid) seen = 1;
        end
        chk({tag, "_out_valid"}, 256'(seen), 256'(1));
        chk({tag, "_out_data"},  256'(strm.out_data), 256'(d));
        chk({tag, "_out_bytes"}, 256'(strm.out_bytes), 256'(nb));
        chk({tag, "_out_last"},  256'(strm.out_last), 256'(lst));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int cyc = 0;
        bit seen = 0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1;
        end
        chk({tag, "_done_seen"}, 256'(seen), 256'(1));
        chk({tag, "_done_cyc"},  256'(cyc), 256'(exp_cyc));
        chk({tag, "_busy_done"}, 256'(busy), 256'(0));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 256'(done), 256'(0));
        @(posedge clk);
        #1;
    endtask

    logic [127:0] t2_in   [3];
    logic [127:0] t2_resp [3];
    logic [127:0] t2_exp  [3];

    initial begin
        bit ok;
        int total;
        logic [127:0] cap;

        reset_n = 1'b0; start = 1'b0; msg_bytes = '0; iv = '0; key = '0; keylen = 1'b0;
        strm.in_valid = 1'b0; strm.in_data = '0; strm.out_ready = 1'b1;
        core_en = 1'b1; core_resp = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ctl", 256'({busy, done, error, strm.in_ready, strm.out_valid, strm.out_last,
                             core_init, core_next, core_finalize}), 256'(0));
        chk("rst_out_data",  256'(strm.out_data), 256'(0));
        chk("rst_out_bytes", 256'(strm.out_bytes), 256'(0));
        chk("rst_key",       core_key, 256'(0));
        chk("rst_blk_iv",    {core_block_i, core_init_counter}, 256'(0));
        chk("rst_len",       256'({core_len_i, core_keylen}), 256'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;

        // T1: AES-128 single full block.
        clr_counts();
        core_resp = 128'h874d6191b620e3261bef6864990db6ce;
        start_msg(16, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff,
                  {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0);
        @(negedge clk);
        chk("t1_init",   256'(core_init), 256'(1));
        chk("t1_busy",   256'(busy), 256'(1));
        chk("t1_iv",     256'(core_init_counter), 256'(128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff));
        chk("t1_key",    core_key, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        chk("t1_keylen", 256'(core_keylen), 256'(0));
        @(posedge clk);
        #1;
        send_block(128'h6bc1bee22e409f96e93d7e117393172a, "t1");
        check_cmd("t1", 1'b0, 1'b1, 8'd128, 128'h6bc1bee22e409f96e93d7e117393172a);
        recv_block(128'h874d6191b620e3261bef6864990db6ce, 5'd16, 1'b1, "t1");
        wait_done("t1", 2);
        chk("t1_cmds", 256'({n_init, n_next, n_fin}), 256'({32'd1, 32'd0, 32'd1}));

        // T2: 40 bytes -> next, next, finalize(64); last block masked to 8 bytes.
        t2_in[0]   = 128'h000102030405060708090a0b0c0d0e0f;
        t2_in[1]   = 128'h101112131415161718191a1b1c1d1e1f;
        t2_in[2]   = 128'h00000000000000002021222324252627;
        t2_resp[0] = 128'h00112233445566778899aabbccddeeff;
        t2_resp[1] = 128'hdeadbeef0123456789abcdeffedcba98;
        t2_resp[2] = {128{1'b1}};
        t2_exp[0]  = 128'h00112233445566778899aabbccddeeff;
        t2_exp[1]  = 128'hdeadbeef0123456789abcdeffedcba98;
        t2_exp[2]  = {64'h0, 64'hffffffffffffffff};
        clr_counts();
        start_msg(40, 128'h0, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b1);
        for (int b = 0; b < 3; b++) begin
            core_resp = t2_resp[b];
            send_block(t2_in[b], $sformatf("t2_b%0d", b));
            check_cmd($sformatf("t2_b%0d", b), (b < 2), (b == 2), 8'd64, t2_in[b]);
            recv_block(t2_exp[b], (b == 2) ? 5'd8 : 5'd16, (b == 2), $sformatf("t2_b%0d", b));
        end
        wait_done("t2", 2);
        chk("t2_cmds",   256'({n_init, n_next, n_fin}), 256'({32'd1, 32'd2, 32'd1}));
        chk("t2_keylen", 256'(core_keylen), 256'(1));

        // T3: empty message -> done without core commands.
        clr_counts();
        start_msg(0, 128'h1, 256'h2, 1'b0);
        wait_done("t3", 2);
        chk("t3_cmds", 256'({n_init, n_next, n_fin}), 256'(0));

        // T4: out_ready stalled for 10 cycles.
        clr_counts();
        strm.out_ready = 1'b0;
        core_resp = 128'hcafef00d_11223344_55667788_99aabbcc;
        start_msg(32, 128'h5, 256'h6, 1'b0);
        send_block(128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5, "t4a");
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (strm.out_valid) ok = 1;
        end
        chk("t4_out_valid", 256'(ok), 256'(1));
        cap   = strm.out_data;
        total = n_init + n_next + n_fin;
        repeat (10) begin
            @(negedge clk);
            if (!strm.out_valid || strm.out_data !== cap || strm.in_ready ||
                core_init || core_next || core_finalize) ok = 0;
        end
        chk("t4_stable",  256'(ok), 256'(1));
        chk("t4_data",    256'(cap), 256'(128'hcafef00d_11223344_55667788_99aabbcc));
        chk("t4_bytes",   256'(strm.out_bytes), 256'(16));
        chk("t4_no_cmd",  256'(n_init + n_next + n_fin), 256'(total));
        @(posedge clk);
        #1 strm.out_ready = 1'b1;
        core_resp = 128'h0f0e0d0c0b0a09080706050403020100;
        send_block(128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a, "t4b");
        check_cmd("t4b", 1'b0, 1'b1, 8'd128, 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a);
        recv_block(128'h0f0e0d0c0b0a09080706050403020100, 5'd16, 1'b1, "t4b");
        wait_done("t4", 2);

        // T5a: start while busy is ignored.
        clr_counts();
        core_resp = 128'h13579bdf2468ace013579bdf2468ace0;
        start_msg(16, 128'h1111, 256'h2222, 1'b0);
        start_msg(48, 128'h9999, 256'h8888, 1'b1);
        @(negedge clk);
        chk("t5_iv_kept",  256'(core_init_counter), 256'(128'h1111));
        chk("t5_key_kept", core_key, 256'h2222);
        @(posedge clk);
        #1;
        send_block(128'h77, "t5");
        check_cmd("t5", 1'b0, 1'b1, 8'd128, 128'h77);
        recv_block(128'h13579bdf2468ace013579bdf2468ace0, 5'd16, 1'b1, "t5");
        wait_done("t5", 2);
        chk("t5_cmds", 256'({n_init, n_next, n_fin}), 256'({32'd1, 32'd0, 32'd1}));

        // T5b: core stalls in WAIT_CORE, then reset mid-message.
        clr_counts();
        start_msg(32, 128'h3333, 256'h4444, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1 core_en = 1'b0;
        send_block(128'hbbbb, "t5b");
        repeat (STALL_CYC) @(negedge clk);
        chk("t5b_stall", 256'({busy, error, strm.out_valid, strm.in_ready}), 256'(4'b1000));
        reset_n = 1'b0;
        #1;
        chk("t5b_rst_ctl", 256'({busy, done, error, strm.in_ready, strm.out_valid, strm.out_last,
                                 core_init, core_next, core_finalize}), 256'(0));
        chk("t5b_rst_blk", {core_block_i, core_init_counter}, 256'(0));
        chk("t5b_rst_out", 256'({strm.out_data, strm.out_bytes}), 256'(0));
        ok = 1;
        repeat (3) begin
            @(negedge clk);
            if (done) ok = 0;
        end
        chk("t5b_no_done", 256'(ok), 256'(1));
        @(posedge clk);
        #1 reset_n = 1'b1;
        core_en = 1'b1;

`ifdef CTR_WATCHDOG_EN
        // T6: core_ready never returns after init -> watchdog abort.
        clr_counts();
        core_en = 1'b0;
        start_msg(16, 128'h55, 256'h66, 1'b0);
        wait_done("t6", 9);
        chk("t6_error", 256'(error), 256'(1));
        chk("t6_cmds",  256'({n_init, n_next, n_fin}), 256'({32'd1, 32'd0, 32'd0}));
        core_en = 1'b1;
        start_msg(0, 128'h0, 256'h0, 1'b0);
        @(negedge clk);
        chk("t6_err_clr", 256'(error), 256'(0));
        @(posedge clk);
        #1;
        wait_done("t6b", 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
